// File: rtl/bus_share_arbiter.sv
`timescale 1ns / 1ps
// bus_share_arbiter
// Round-robin owner selection for one shared bus driven by NREQ octal tri-state buffers.
// Each buffer has an active-low output enable. Between two owners the arbiter holds every
// enable high for TURN_CYC cycles. bus_y_o is a muxed copy of the bus for fabrics that
// have no internal tri-states.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i        level request per source, held for the whole transfer
//   src_data_i   source data, slice i belongs to source i
//   oe_n_o       active-low enable per buffer (G1n/G2n)
//   grant_o      one-hot current owner, zero when the bus floats
//   owner_o      index of the current owner, valid while busy_o
//   busy_o       a source is enabled this cycle
//   bus_y_o      owner's data while busy, PULL_VAL otherwise
//   preempt_o    one-cycle pulse after an owner is released by MAX_HOLD
module bus_share_arbiter #(
    parameter int unsigned   NREQ     = 4,            // 2..8
    parameter int unsigned   DW       = 8,
    parameter int unsigned   TURN_CYC = 1,            // 1..15
    parameter int unsigned   MAX_HOLD = 0,            // 0 = unlimited
    parameter logic [DW-1:0] PULL_VAL = {DW{1'b1}}
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*DW-1:0] src_data_i,
    output logic [NREQ-1:0]    oe_n_o,
    output logic [NREQ-1:0]    grant_o,
    output logic [2:0]         owner_o,
    output logic               busy_o,
    output logic [DW-1:0]      bus_y_o,
    output logic               preempt_o
);

    typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

    localparam int unsigned     HoldW    = 16;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
    localparam logic [3:0]      TurnInit = 4'(TURN_CYC);
    localparam logic [2:0]      LastIdx  = 3'(NREQ - 1);

    state_e           state_q, state_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [3:0]       turn_q, turn_d;
    logic             preempt_q, preempt_d;

    logic [2*NREQ-1:0] req_rot;
    logic              pick_vld;
    logic [2:0]        pick_idx;
    logic [3:0]        pick_sum;
    logic              own_req;
    logic              hold_hit;
    logic [2:0]        ptr_after_owner;

    // Rotate the request vector so bit 0 is the source at the pointer; the first set bit
    // of the rotated vector is the winner, mapped back by adding the pointer mod NREQ.
    always_comb begin
        req_rot  = {req_i, req_i} >> ptr_q;
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_sum = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_vld && req_rot[i]) begin
                pick_vld = 1'b1;
                pick_sum = {1'b0, ptr_q} + 4'(i);
                if (pick_sum >= 4'(NREQ)) begin
                    pick_sum = pick_sum - 4'(NREQ);
                end
                pick_idx = pick_sum[2:0];
            end
        end
    end

    assign own_req         = |(req_i & grant_o);
    assign hold_hit        = (MAX_HOLD != 0) && (hold_q >= HoldMax);
    // The released owner becomes lowest priority.
    assign ptr_after_owner = (owner_q == LastIdx) ? 3'd0 : owner_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        preempt_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    state_d = StOwn;
                    owner_d = pick_idx;
                    hold_d  = HoldW'(1);
                end
            end
            StOwn: begin
                // A dropped request and a hold timeout both release; new requests never
                // take over directly, they wait for the turnaround.
                if (!own_req || hold_hit) begin
                    state_d   = StTurn;
                    ptr_d     = ptr_after_owner;
                    turn_d    = TurnInit;
                    hold_d    = '0;
                    preempt_d = own_req;
                end else if ((MAX_HOLD != 0) && (hold_q < HoldMax)) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StTurn: begin
                // The last dead cycle doubles as the arbitration cycle.
                if (turn_q <= 4'd1) begin
                    if (pick_vld) begin
                        state_d = StOwn;
                        owner_d = pick_idx;
                        hold_d  = HoldW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                    turn_d = '0;
                end else begin
                    turn_d = turn_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            preempt_q <= preempt_d;
        end
    end

    // Enables and the muxed bus come only from registered state, so the reset clears
    // every enable without waiting for a clock edge.
    always_comb begin
        busy_o  = (state_q == StOwn);
        grant_o = '0;
        bus_y_o = PULL_VAL;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (busy_o && (owner_q == 3'(i))) begin
                grant_o[i] = 1'b1;
                bus_y_o    = src_data_i[i*DW +: DW];
            end
        end
    end

    assign oe_n_o    = ~grant_o;
    assign owner_o   = owner_q;
    assign preempt_o = preempt_q;

endmodule

// File: tb/tb_bus_share_arbiter.sv
`timescale 1ns / 1ps
// Testbench for bus_share_arbiter. Instance A uses the defaults (TURN_CYC=1, MAX_HOLD=0);
// instance B uses TURN_CYC=2, MAX_HOLD=4. Outputs are sampled on the falling edge.
module tb_bus_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic               rst_n;
    logic [NREQ-1:0]    req_a, req_b;
    logic [NREQ*DW-1:0] src_data;
    logic [NREQ-1:0]    oe_n_a, grant_a, oe_n_b, grant_b;
    logic [2:0]         owner_a, owner_b;
    logic               busy_a, busy_b, pre_a, pre_b;
    logic [DW-1:0]      bus_a, bus_b;

    int checks   = 0;
    int failures = 0;

    bus_share_arbiter #(.NREQ(NREQ), .DW(DW), .TURN_CYC(1), .MAX_HOLD(0)) u_dut_a (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .req_i      (req_a),
        .src_data_i (src_data),
        .oe_n_o     (oe_n_a),
        .grant_o    (grant_a),
        .owner_o    (owner_a),
        .busy_o     (busy_a),
        .bus_y_o    (bus_a),
        .preempt_o  (pre_a)
    );

    bus_share_arbiter #(.NREQ(NREQ), .DW(DW), .TURN_CYC(2), .MAX_HOLD(4)) u_dut_b (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .req_i      (req_b),
        .src_data_i (src_data),
        .oe_n_o     (oe_n_b),
        .grant_o    (grant_b),
        .owner_o    (owner_b),
        .busy_o     (busy_b),
        .bus_y_o    (bus_b),
        .preempt_o  (pre_b)
    );

    // Reference-model state for the random test, indexed by instance.
    int m_busy  [2];
    int m_owner [2];
    int m_hold  [2];
    int m_dead  [2];
    int m_seen  [2];
    int ob_prev [2];
    int wait_c  [2][NREQ];

    task automatic apply_reset();
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req_a    = '0;
        req_b    = '0;
        src_data = 32'h5a3c_9612;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            checks += 4;
            if (oe_n_a !== 4'hf) begin
                failures++; $display("FAIL reset_oe_n: got %b want 1111", oe_n_a);
            end
            if (busy_a !== 1'b0 || grant_a !== 4'h0 || owner_a !== 3'd0) begin
                failures++;
                $display("FAIL reset_state: busy %b grant %b owner %0d want 0 0000 0",
                         busy_a, grant_a, owner_a);
            end
            if (bus_a !== 8'hff) begin
                failures++; $display("FAIL reset_bus_y: got %h want ff", bus_a);
            end
            if (pre_a !== 1'b0 || oe_n_b !== 4'hf) begin
                failures++; $display("FAIL reset_misc: preempt %b oe_n_b %b want 0 1111",
                                     pre_a, oe_n_b);
            end
        end
        req_a = 4'b0100;
        rst_n = 1'b1;
        @(negedge clk_i);
        checks += 2;
        if (oe_n_a !== 4'b1011) begin
            failures++; $display("FAIL first_grant_oe_n: got %b want 1011", oe_n_a);
        end
        if (owner_a !== 3'd2 || busy_a !== 1'b1) begin
            failures++; $display("FAIL first_grant_owner: got %0d busy %b want 2 busy 1",
                                 owner_a, busy_a);
        end
        req_a = '0;
    endtask

    task automatic test_handoff();
        apply_reset();
        src_data = 32'h3322_a511;
        req_a    = 4'b0011;
        @(negedge clk_i);
        checks += 2;
        if (oe_n_a !== 4'b1110 || owner_a !== 3'd0) begin
            failures++; $display("FAIL handoff_first: oe_n %b owner %0d want 1110 0",
                                 oe_n_a, owner_a);
        end
        if (bus_a !== 8'h11) begin
            failures++; $display("FAIL handoff_bus0: got %h want 11", bus_a);
        end
        req_a = 4'b0010;
        @(negedge clk_i);
        checks += 2;
        if (oe_n_a !== 4'hf || busy_a !== 1'b0) begin
            failures++; $display("FAIL handoff_dead: oe_n %b busy %b want 1111 0",
                                 oe_n_a, busy_a);
        end
        if (bus_a !== 8'hff) begin
            failures++; $display("FAIL handoff_dead_bus: got %h want ff", bus_a);
        end
        @(negedge clk_i);
        checks += 2;
        if (oe_n_a !== 4'b1101 || owner_a !== 3'd1) begin
            failures++; $display("FAIL handoff_second: oe_n %b owner %0d want 1101 1",
                                 oe_n_a, owner_a);
        end
        if (bus_a !== 8'ha5) begin
            failures++; $display("FAIL handoff_bus1: got %h want a5", bus_a);
        end
        req_a = 4'b0000;
        @(negedge clk_i);
        checks++;
        if (oe_n_a !== 4'hf || bus_a !== 8'hff) begin
            failures++; $display("FAIL handoff_release: oe_n %b bus %h want 1111 ff",
                                 oe_n_a, bus_a);
        end
        @(negedge clk_i);
        checks++;
        if (busy_a !== 1'b0) begin
            failures++; $display("FAIL handoff_idle: busy %b want 0", busy_a);
        end
    endtask

    task automatic test_preempt();
        logic [NREQ-1:0] exp_oe;
        int o;
        apply_reset();
        src_data = $urandom;
        req_b    = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            o      = g % NREQ;
            exp_oe = ~(4'b0001 << o);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk_i);
                checks += 3;
                if (busy_b !== 1'b1 || int'(owner_b) != o) begin
                    failures++; $display("FAIL preempt_owner g%0d c%0d: busy %b owner %0d want 1 %0d",
                                         g, c, busy_b, owner_b, o);
                end
                if (oe_n_b !== exp_oe || pre_b !== 1'b0) begin
                    failures++; $display("FAIL preempt_oe g%0d c%0d: oe_n %b pre %b want %b 0",
                                         g, c, oe_n_b, pre_b, exp_oe);
                end
                if (bus_b !== src_data[o*DW +: DW]) begin
                    failures++; $display("FAIL preempt_bus g%0d: got %h want %h",
                                         g, bus_b, src_data[o*DW +: DW]);
                end
            end
            if (g < 4) begin
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk_i);
                    checks += 2;
                    if (oe_n_b !== 4'hf || busy_b !== 1'b0 || bus_b !== 8'hff) begin
                        failures++; $display("FAIL preempt_gap g%0d k%0d: oe_n %b busy %b bus %h",
                                             g, k, oe_n_b, busy_b, bus_b);
                    end
                    if (pre_b !== (k == 0)) begin
                        failures++; $display("FAIL preempt_pulse g%0d k%0d: got %b want %0d",
                                             g, k, pre_b, (k == 0));
                    end
                end
            end
        end
        req_b = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_a = 4'b0001;
        @(negedge clk_i);
        req_a = 4'b0000;
        @(negedge clk_i);
        req_a = 4'b1000;
        @(negedge clk_i);
        checks++;
        if (owner_a !== 3'd3 || oe_n_a !== 4'b0111) begin
            failures++; $display("FAIL midreset_setup: owner %0d oe_n %b want 3 0111",
                                 owner_a, oe_n_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (oe_n_a !== 4'hf || busy_a !== 1'b0 || bus_a !== 8'hff) begin
            failures++; $display("FAIL midreset_async: oe_n %b busy %b bus %h want 1111 0 ff",
                                 oe_n_a, busy_a, bus_a);
        end
        req_a = 4'b1001;
        @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        checks++;
        if (owner_a !== 3'd0 || oe_n_a !== 4'b1110) begin
            failures++; $display("FAIL midreset_ptr: owner %0d oe_n %b want 0 1110",
                                 owner_a, oe_n_a);
        end
        req_a = '0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] rq, o_grant, o_oe, e_grant;
        logic [2:0]      o_owner;
        logic            o_busy, o_pre;
        logic [DW-1:0]   o_bus, e_bus;
        int tc, mh, e_busy, e_owner, e_pre, ptr, idx;
        apply_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_owner[d] = 0; m_hold[d] = 0; m_dead[d] = 0;
            m_seen[d] = 0; ob_prev[d] = 0;
            for (int i = 0; i < NREQ; i++) wait_c[d][i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            // Requests rise randomly and drop only while granted, so waiters persist.
            for (int d = 0; d < 2; d++) begin
                rq      = (d == 0) ? req_a : req_b;
                o_grant = (d == 0) ? grant_a : grant_b;
                for (int i = 0; i < NREQ; i++) begin
                    if (!rq[i]) begin
                        if ($urandom_range(3) == 0) rq[i] = 1'b1;
                    end else if (o_grant[i] && $urandom_range(2) == 0) begin
                        rq[i] = 1'b0;
                    end
                end
                if (d == 0) req_a = rq; else req_b = rq;
            end
            src_data = $urandom;
            @(negedge clk_i);
            for (int d = 0; d < 2; d++) begin
                tc      = (d == 0) ? 1 : 2;
                mh      = (d == 0) ? 0 : 4;
                rq      = (d == 0) ? req_a : req_b;
                o_grant = (d == 0) ? grant_a : grant_b;
                o_oe    = (d == 0) ? oe_n_a : oe_n_b;
                o_owner = (d == 0) ? owner_a : owner_b;
                o_busy  = (d == 0) ? busy_a : busy_b;
                o_pre   = (d == 0) ? pre_a : pre_b;
                o_bus   = (d == 0) ? bus_a : bus_b;
                e_owner = m_owner[d];
                e_pre   = 0;
                if (m_busy[d] != 0) begin
                    e_busy = (rq[m_owner[d]] && (mh == 0 || m_hold[d] < mh)) ? 1 : 0;
                    e_pre  = (rq[m_owner[d]] && e_busy == 0) ? 1 : 0;
                end else begin
                    e_busy = (rq != 0 && (m_seen[d] == 0 || m_dead[d] >= tc)) ? 1 : 0;
                    if (e_busy != 0) begin
                        ptr = (m_seen[d] != 0) ? (m_owner[d] + 1) % NREQ : 0;
                        for (int k = NREQ - 1; k >= 0; k--) begin
                            idx = (ptr + k) % NREQ;
                            if (rq[idx]) e_owner = idx;
                        end
                    end
                end
                e_grant = (e_busy != 0) ? (4'b0001 << e_owner) : 4'b0000;
                e_bus   = (e_busy != 0) ? src_data[e_owner*DW +: DW] : 8'hff;
                checks += 5;
                if (o_grant !== e_grant || o_oe !== ~e_grant) begin
                    failures++; $display("FAIL rand_grant dut%0d cyc%0d: grant %b oe_n %b want %b",
                                         d, cyc, o_grant, o_oe, e_grant);
                end
                if (o_busy !== (e_busy != 0)) begin
                    failures++; $display("FAIL rand_busy dut%0d cyc%0d: got %b want %0d",
                                         d, cyc, o_busy, e_busy);
                end
                if (o_pre !== (e_pre != 0)) begin
                    failures++; $display("FAIL rand_preempt dut%0d cyc%0d: got %b want %0d",
                                         d, cyc, o_pre, e_pre);
                end
                if (o_bus !== e_bus) begin
                    failures++; $display("FAIL rand_bus dut%0d cyc%0d: got %h want %h",
                                         d, cyc, o_bus, e_bus);
                end
                if (e_busy != 0 && int'(o_owner) != e_owner) begin
                    failures++; $display("FAIL rand_owner dut%0d cyc%0d: got %0d want %0d",
                                         d, cyc, o_owner, e_owner);
                end
                // Fairness measured on the DUT's own grants: a steady waiter sees at most
                // NREQ-1 other grant windows open before its own.
                if (o_busy === 1'b1 && ob_prev[d] == 0) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (i == int'(o_owner)) begin
                            wait_c[d][i] = 0;
                        end else if (rq[i]) begin
                            wait_c[d][i]++;
                            checks++;
                            if (wait_c[d][i] > NREQ - 1) begin
                                failures++; $display("FAIL rand_fair dut%0d src%0d: waited %0d windows",
                                                     d, i, wait_c[d][i]);
                            end
                        end
                    end
                end
                for (int i = 0; i < NREQ; i++) if (!rq[i]) wait_c[d][i] = 0;
                ob_prev[d] = (o_busy === 1'b1) ? 1 : 0;
                if (e_busy != 0) begin
                    m_hold[d] = (m_busy[d] != 0) ? m_hold[d] + 1 : 1;
                    m_dead[d] = 0;
                    m_seen[d] = 1;
                end else begin
                    m_hold[d] = 0;
                    if (m_dead[d] < 100) m_dead[d]++;
                end
                m_busy[d]  = e_busy;
                m_owner[d] = e_owner;
            end
        end
        req_a = '0;
        req_b = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        req_a    = '0;
        req_b    = '0;
        src_data = '0;
        test_reset();
        test_handoff();
        test_preempt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
